i2c_codec_target: RTL and testbench
===================================

// Module: i2c_codec_target
// PURPOSE
//  I2C write-only target (slave) with a WM8731-style 9-bit register file.
//  Receives the configuration frames produced by our I2C config master:
//  START, addr+W, {reg[6:0],d[8]}, d[7:0], STOP.
//  Serves as the on-chip codec-register model for sim and loopback bring-up.
//  Exposes a write strobe and a read port to the audio datapath.
// PARAMETERS
//  DEV_ADDR     7'h1A  7-bit device address this target ACKs
//  NUM_REGS     16     register-file depth; valid reg addrs 0..NUM_REGS-1
//  RESET_REG    7'h0F  writing any data to this reg clears the whole file
//  SYNC_STAGES  2      flops in the scl_in/sda_in synchronisers (>=2)
// PORTS
//  clk        in   1  system clock; must be >= 8x the SCL rate
//  reset      in   1  synchronous, active-high
//  scl_in     in   1  raw SCL from the bus (async)
//  sda_in     in   1  raw SDA from the bus (async)
//  sda_oe     out  1  1 = pull SDA low (open drain); 0 = release
//  wr_valid   out  1  one-cycle pulse: register write committed
//  wr_addr    out  7  register address of the last committed write
//  wr_data    out  9  data of the last committed write
//  rd_addr    in   4  register-file read address ($clog2(NUM_REGS) bits)
//  rd_data    out  9  regs[rd_addr], combinational read
//  busy       out  1  1 from START detection to STOP detection
//  addr_err   out  1  one-cycle pulse: write dropped, reg addr >= NUM_REGS
// BEHAVIOUR
//  Reset: all outputs 0, all regs 0, FSM IDLE, bit counter 0; dominates any bus activity.
//  Front end: scl/sda go through SYNC_STAGES flops. One further flop holds the previous value.
//  Edges are decoded from the synchronised value vs. the previous value.
//  START = sda fall with scl high; STOP = sda rise with scl high.
//  Both are valid in every state.
//  START (incl. repeated): FSM->ADDR, bit counter 0, sda_oe 0, busy 1.
//  STOP: FSM->IDLE, sda_oe 0, busy 0; a partial frame is discarded with no write.
//  Data bits: sampled MSB first on synchronised scl rising edge; sda is ignored while scl is low.
//  States:
//   IDLE  : waits for START.
//   ADDR  : 8 bits. After the 8th bit: addr==DEV_ADDR and R/W=0 -> ACK_A;
//           otherwise -> IGNORE (NACK, sda_oe stays 0).
//   ACK_A : sda_oe=1 from the next scl fall to the following scl fall; then -> BYTE1.
//   BYTE1 : 8 bits -> shift reg; ACK_1 (same ACK timing) -> BYTE2.
//   BYTE2 : 8 bits; ACK_2 -> DONE.
//   DONE  : further bytes are NACKed and dropped; waits for STOP or START.
//   IGNORE: sda_oe=0; waits for STOP or START.
//  Commit: on the scl rising edge of BYTE2 bit 8.
//   reg = byte1[7:1], data = {byte1[0], byte2}.
//   wr_valid pulses exactly one clk later; it is registered.
//   wr_valid is high SYNC_STAGES+2 clk cycles after the first clk edge sampling scl_in=1.
//  wr_addr/wr_data update with every wr_valid and hold otherwise.
//   reg == RESET_REG: all regs cleared to 0 in the wr_valid cycle.
//   reg < NUM_REGS (and != RESET_REG): regs[reg] <= data.
//   otherwise: no regs change, addr_err pulses with wr_valid; the frame is still ACKed.
//  rd_data reflects a write the cycle after wr_valid.
//  sda_oe changes only on the cycle after a synchronised scl fall (or on STOP/START/reset).
//  It never changes while scl is high.
// TESTING
//  1. Frame 0x34, 0x0E, 0x42 + STOP -> 3 ACKs; wr_valid once; wr_addr=7, wr_data=0x042; rd_addr=7 -> 0x042.
//  2. Frame 0x36 (addr 0x1B) -> sda_oe never 1, no wr_valid; busy 1 until STOP.
//     Frame 0x35 (read of 0x1A) -> same.
//  3. Load regs 2,4 = 0x079, 0x012; write reg 0x0F data 0x000 -> all rd_data 0.
//  4. 0x34, 0x20, 0x55 (reg 16) -> ACKed; addr_err + wr_valid pulse; regs unchanged.
//  5. STOP after BYTE1; repeated START mid-BYTE2 followed by a full frame -> only the full frame writes.
//     A 3rd data byte is NACKed.
//  6. reset asserted mid-BYTE1 -> next clk: sda_oe=0, busy=0, regs 0; next full frame writes normally.

Source files
------------

// File: rtl/i2c_codec_target_if.sv
// rtl/i2c_codec_target_if.sv - I2C pins, register write strobe and read port of the codec target
//
// Purpose: bundles the bus pins and datapath-facing signals of i2c_codec_target.
// Ports (slave view, as seen by the target):
//   scl_in, sda_in  in   raw I2C lines (asynchronous)
//   sda_oe          out  1 = pull SDA low
//   wr_valid        out  one-cycle pulse per committed register write
//   wr_addr/wr_data out  register address / 9-bit data of the last write
//   rd_addr         in   register-file read address
//   rd_data         out  regs[rd_addr], combinational
//   busy            out  high between START and STOP
//   addr_err        out  pulses with wr_valid when the register address is out of range
interface i2c_codec_target_if #(
   parameter int AW = 4
);
   logic          scl_in;
   logic          sda_in;
   logic          sda_oe;
   logic          wr_valid;
   logic [6:0]    wr_addr;
   logic [8:0]    wr_data;
   logic [AW-1:0] rd_addr;
   logic [8:0]    rd_data;
   logic          busy;
   logic          addr_err;

   modport slave (
      input  scl_in, sda_in, rd_addr,
      output sda_oe, wr_valid, wr_addr, wr_data, rd_data, busy, addr_err
   );

   modport master (
      output scl_in, sda_in, rd_addr,
      input  sda_oe, wr_valid, wr_addr, wr_data, rd_data, busy, addr_err
   );
endinterface

// File: rtl/i2c_codec_target.sv
// rtl/i2c_codec_target.sv - write-only I2C target with a WM8731-style 9-bit register file
//
// Purpose: accepts START, addr+W, {reg[6:0],d[8]}, d[7:0], STOP frames and
// writes the 9-bit value into a small register file.
// Ports:
//   clk    in  system clock (>= 8x SCL rate)
//   reset  in  synchronous, active-high
//   bus    slave modport of i2c_codec_target_if (I2C pins, write strobe, read port)
module i2c_codec_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         NUM_REGS    = 16,
   parameter logic [6:0] RESET_REG   = 7'h0F,
   parameter int         SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               reset,
   i2c_codec_target_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, DONE, IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_prev, sda_prev;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   state_t     state, state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] shift, shift_n, byte1, byte1_n, byte_n;
   logic       sda_oe, sda_oe_n, busy, busy_n;
   logic       commit, commit_n;
   logic       byte_done, in_data_state;

   logic       wr_valid, addr_err;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic [8:0] regs [NUM_REGS];

   // Synchronisers reset to 1 so an idle bus is not mistaken for an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign start_det = scl_s & sda_prev & ~sda_s;
   assign stop_det  = scl_s & ~sda_prev & sda_s;

   assign byte_n        = {shift[6:0], sda_s};
   assign byte_done     = scl_rise && (bit_cnt == 3'd7);
   assign in_data_state = (state == ADDR) || (state == BYTE1) || (state == BYTE2);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= 3'd0;
         shift   <= 8'h00;
         byte1   <= 8'h00;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         commit  <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shift   <= shift_n;
         byte1   <= byte1_n;
         sda_oe  <= sda_oe_n;
         busy    <= busy_n;
         commit  <= commit_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      byte1_n   = byte1;
      sda_oe_n  = sda_oe;
      busy_n    = busy;
      commit_n  = 1'b0;
      if (start_det) begin
         state_n   = ADDR;
         bit_cnt_n = 3'd0;
         sda_oe_n  = 1'b0;
         busy_n    = 1'b1;
      end else if (stop_det) begin
         state_n   = IDLE;
         bit_cnt_n = 3'd0;
         sda_oe_n  = 1'b0;
         busy_n    = 1'b0;
      end else begin
         // The 3-bit counter wraps to 0 after the 8th bit, ready for the next byte.
         if (scl_rise && in_data_state) begin
            shift_n   = byte_n;
            bit_cnt_n = bit_cnt + 3'd1;
         end
         case (state)
            ADDR: begin
               if (byte_done) begin
                  state_n = (byte_n[7:1] == DEV_ADDR && !byte_n[0]) ? ACK_A : IGNORE;
               end
            end
            BYTE1: begin
               if (byte_done) begin
                  byte1_n = byte_n;
                  state_n = ACK_1;
               end
            end
            BYTE2: begin
               if (byte_done) begin
                  commit_n = 1'b1;
                  state_n  = ACK_2;
               end
            end
            // ACK: the first scl fall (end of bit 8) pulls SDA, the next fall releases it.
            ACK_A: begin
               if (scl_fall) begin
                  sda_oe_n = ~sda_oe;
                  if (sda_oe) state_n = BYTE1;
               end
            end
            ACK_1: begin
               if (scl_fall) begin
                  sda_oe_n = ~sda_oe;
                  if (sda_oe) state_n = BYTE2;
               end
            end
            ACK_2: begin
               if (scl_fall) begin
                  sda_oe_n = ~sda_oe;
                  if (sda_oe) state_n = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // shift still holds byte2 here: no scl rise can occur one clk after the commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_valid <= 1'b0;
         wr_addr  <= 7'h00;
         wr_data  <= 9'h000;
         addr_err <= 1'b0;
      end else begin
         wr_valid <= commit;
         addr_err <= 1'b0;
         if (commit) begin
            wr_addr  <= byte1[7:1];
            wr_data  <= {byte1[0], shift};
            addr_err <= (byte1[7:1] != RESET_REG) && (byte1[7:1] >= 7'(NUM_REGS));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'h000;
      end else if (wr_valid) begin
         if (wr_addr == RESET_REG) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'h000;
         end else if (wr_addr < 7'(NUM_REGS)) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
         end
      end
   end

   assign bus.sda_oe   = sda_oe;
   assign bus.busy     = busy;
   assign bus.wr_valid = wr_valid;
   assign bus.wr_addr  = wr_addr;
   assign bus.wr_data  = wr_data;
   assign bus.addr_err = addr_err;
   assign bus.rd_data  = regs[bus.rd_addr];
endmodule

// File: tb/tb_i2c_codec_target.sv
// tb/tb_i2c_codec_target.sv - self-checking bench for i2c_codec_target
module tb_i2c_codec_target;
   localparam int SYNC_STAGES = 2;
   localparam int Q           = 5;
   localparam logic [7:0] AW_BYTE = 8'h34;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic [3:0] rd_addr_drv = 4'd0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_rise_cyc = 0;
   int oe_high = 0;
   int scl_hi = 0;
   logic prev_wv = 1'b0;
   logic prev_oe = 1'b0;

   logic [6:0] ev_addr [$];
   logic [8:0] ev_data [$];
   logic       ev_err  [$];
   logic [8:0] model [16];

   i2c_codec_target_if #(.AW(4)) bus ();
   assign bus.scl_in  = scl_drv;
   assign bus.sda_in  = sda_drv & ~bus.sda_oe;
   assign bus.rd_addr = rd_addr_drv;

   i2c_codec_target #(
      .DEV_ADDR(7'h1A), .NUM_REGS(16), .RESET_REG(7'h0F), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: records every write, checks pulse width, latency and sda_oe timing.
   always @(negedge clk) begin
      if (bus.wr_valid) begin
         ev_addr.push_back(bus.wr_addr);
         ev_data.push_back(bus.wr_data);
         ev_err.push_back(bus.addr_err);
         total++;
         if (prev_wv) begin
            bad++;
            $display("FAIL wr_valid_width: high for 2+ cycles, required 1");
         end
         total++;
         if (cyc - last_rise_cyc != SYNC_STAGES + 2) begin
            bad++;
            $display("FAIL wr_latency: got %0d cycles, required %0d", cyc - last_rise_cyc, SYNC_STAGES + 2);
         end
      end else if (bus.addr_err) begin
         total++;
         bad++;
         $display("FAIL addr_err_alone: addr_err=1 without wr_valid, required 0");
      end
      if (bus.sda_oe !== prev_oe) begin
         total++;
         if (scl_hi >= 4) begin
            bad++;
            $display("FAIL sda_oe_scl_high: sda_oe changed to %b with scl high %0d cycles", bus.sda_oe, scl_hi);
         end
      end
      if (bus.sda_oe) oe_high++;
      prev_oe = bus.sda_oe;
      prev_wv = bus.wr_valid;
      scl_hi  = bus.scl_in ? scl_hi + 1 : 0;
   end

   task automatic wait_q(input int n);
      repeat (n * Q) @(negedge clk);
   endtask

   task automatic scl_set(input logic v);
      if (v && !scl_drv) last_rise_cyc = cyc;
      scl_drv = v;
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; wait_q(1);
      scl_set(1'b1);  wait_q(1);
      sda_drv = 1'b0; wait_q(1);
      scl_set(1'b0);  wait_q(1);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wait_q(1);
      scl_set(1'b1);  wait_q(1);
      sda_drv = 1'b1; wait_q(1);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_drv = b[i]; wait_q(1);
         scl_set(1'b1);  wait_q(2);
         scl_set(1'b0);  wait_q(1);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      sda_drv = 1'b1; wait_q(1);
      scl_set(1'b1);  wait_q(1);
      ack = bus.sda_oe;
      wait_q(1);
      scl_set(1'b0);  wait_q(1);
   endtask

   task automatic send_frame(input logic [7:0] a, b1, b2, output logic [2:0] acks);
      logic k;
      i2c_start();
      send_byte(a, k);  acks[2] = k;
      send_byte(b1, k); acks[1] = k;
      send_byte(b2, k); acks[0] = k;
      i2c_stop();
   endtask

   // Reference register-file semantics: reg = b1[7:1], data = {b1[0], b2}.
   function automatic void model_write(input logic [7:0] b1, b2);
      logic [6:0] r;
      r = b1[7:1];
      if (r == 7'h0F) begin
         for (int i = 0; i < 16; i++) model[i] = 9'h000;
      end else if (r < 7'd16) begin
         model[r[3:0]] = {b1[0], b2};
      end
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 16; i++) model[i] = 9'h000;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if (bus.sda_oe !== 1'b0)   begin bad++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
      total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid); end
      total++; if (bus.wr_addr !== 7'h00 || bus.wr_data !== 9'h000) begin
         bad++; $display("FAIL reset_wr_bus: got %h/%h want 00/000", bus.wr_addr, bus.wr_data);
      end
      for (int r = 0; r < 16; r++) begin
         rd_addr_drv = 4'(r); @(negedge clk);
         total++; if (bus.rd_data !== 9'h000) begin bad++; $display("FAIL reset_reg%0d: got %h want 000", r, bus.rd_data); end
      end
   endtask

   task automatic test_basic_write();
      logic [2:0] acks;
      send_frame(AW_BYTE, 8'h0E, 8'h42, acks);
      total++; if (acks !== 3'b111) begin bad++; $display("FAIL basic_acks: got %b want 111", acks); end
      total++;
      if (ev_addr.size() != 1) begin
         bad++; $display("FAIL basic_wr_count: got %0d want 1", ev_addr.size());
      end else if (ev_addr[0] !== 7'h07 || ev_data[0] !== 9'h042 || ev_err[0] !== 1'b0) begin
         bad++; $display("FAIL basic_wr: got %h/%h/%b want 07/042/0", ev_addr[0], ev_data[0], ev_err[0]);
      end
      ev_addr.delete(); ev_data.delete(); ev_err.delete();
      model_write(8'h0E, 8'h42);
      rd_addr_drv = 4'd7; @(negedge clk);
      total++; if (bus.rd_data !== 9'h042) begin bad++; $display("FAIL basic_rd: got %h want 042", bus.rd_data); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after_stop: got %b want 0", bus.busy); end
   endtask

   task automatic test_no_match();
      logic [7:0] addrs [2];
      logic [2:0] acks;
      logic k;
      int oe0;
      addrs[0] = 8'h36;
      addrs[1] = 8'h35;
      for (int n = 0; n < 2; n++) begin
         oe0 = oe_high;
         i2c_start();
         send_byte(addrs[n], k); acks[2] = k;
         total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL nomatch_busy_%h: got %b want 1", addrs[n], bus.busy); end
         send_byte(8'h0E, k); acks[1] = k;
         send_byte(8'h42, k); acks[0] = k;
         total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL nomatch_busy_late_%h: got %b want 1", addrs[n], bus.busy); end
         i2c_stop();
         total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL nomatch_busy_stop_%h: got %b want 0", addrs[n], bus.busy); end
         total++; if (acks !== 3'b000) begin bad++; $display("FAIL nomatch_acks_%h: got %b want 000", addrs[n], acks); end
         total++; if (oe_high != oe0) begin bad++; $display("FAIL nomatch_oe_%h: sda_oe high %0d cycles want 0", addrs[n], oe_high - oe0); end
         total++; if (ev_addr.size() != 0) begin bad++; $display("FAIL nomatch_wr_%h: got %0d writes want 0", addrs[n], ev_addr.size()); end
         ev_addr.delete(); ev_data.delete(); ev_err.delete();
      end
   endtask

   task automatic test_clear();
      logic [2:0] acks;
      send_frame(AW_BYTE, 8'h04, 8'h79, acks); model_write(8'h04, 8'h79);
      send_frame(AW_BYTE, 8'h08, 8'h12, acks); model_write(8'h08, 8'h12);
      rd_addr_drv = 4'd2; @(negedge clk);
      total++; if (bus.rd_data !== 9'h079) begin bad++; $display("FAIL clear_pre_reg2: got %h want 079", bus.rd_data); end
      rd_addr_drv = 4'd4; @(negedge clk);
      total++; if (bus.rd_data !== 9'h012) begin bad++; $display("FAIL clear_pre_reg4: got %h want 012", bus.rd_data); end
      ev_addr.delete(); ev_data.delete(); ev_err.delete();
      send_frame(AW_BYTE, 8'h1E, 8'h00, acks);
      model_write(8'h1E, 8'h00);
      total++; if (acks !== 3'b111) begin bad++; $display("FAIL clear_acks: got %b want 111", acks); end
      total++;
      if (ev_addr.size() != 1 || ev_addr[0] !== 7'h0F || ev_err[0] !== 1'b0) begin
         bad++; $display("FAIL clear_wr: got %0d writes (first addr %h) want 1 at 0F", ev_addr.size(), ev_addr.size() ? ev_addr[0] : 7'h00);
      end
      ev_addr.delete(); ev_data.delete(); ev_err.delete();
      for (int r = 0; r < 16; r++) begin
         rd_addr_drv = 4'(r); @(negedge clk);
         total++; if (bus.rd_data !== 9'h000) begin bad++; $display("FAIL clear_reg%0d: got %h want 000", r, bus.rd_data); end
      end
   endtask

   task automatic test_addr_err();
      logic [2:0] acks;
      send_frame(AW_BYTE, 8'h0B, 8'hA5, acks); model_write(8'h0B, 8'hA5);
      ev_addr.delete(); ev_data.delete(); ev_err.delete();
      send_frame(AW_BYTE, 8'h20, 8'h55, acks);
      model_write(8'h20, 8'h55);
      total++; if (acks !== 3'b111) begin bad++; $display("FAIL adderr_acks: got %b want 111", acks); end
      total++;
      if (ev_addr.size() != 1) begin
         bad++; $display("FAIL adderr_count: got %0d want 1", ev_addr.size());
      end else if (ev_addr[0] !== 7'h10 || ev_data[0] !== 9'h055 || ev_err[0] !== 1'b1) begin
         bad++; $display("FAIL adderr_wr: got %h/%h/%b want 10/055/1", ev_addr[0], ev_data[0], ev_err[0]);
      end
      ev_addr.delete(); ev_data.delete(); ev_err.delete();
      for (int r = 0; r < 16; r++) begin
         rd_addr_drv = 4'(r); @(negedge clk);
         total++; if (bus.rd_data !== model[r]) begin bad++; $display("FAIL adderr_reg%0d: got %h want %h", r, bus.rd_data, model[r]); end
      end
   endtask

   task automatic test_partial_frames();
      logic k;
      logic [7:0] b1, b2;
      b1 = {4'(3'($urandom_range(1, 6))), 4'($urandom)} & 8'h1F;
      b2 = 8'($urandom);
      i2c_start();
      send_byte(AW_BYTE, k);
      send_byte(8'h06, k);
      i2c_stop();
      total++; if (ev_addr.size() != 0) begin bad++; $display("FAIL partial_stop: got %0d writes want 0", ev_addr.size()); end
      i2c_start();
      send_byte(AW_BYTE, k);
      send_byte(8'h08, k);
      send_bits(8'hFF, 4);
      i2c_start();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL partial_rs_busy: got %b want 1", bus.busy); end
      send_byte(AW_BYTE, k);
      total++; if (k !== 1'b1) begin bad++; $display("FAIL partial_rs_addr_ack: got %b want 1", k); end
      send_byte(b1, k);
      send_byte(b2, k);
      send_byte(8'h5A, k);
      total++; if (k !== 1'b0) begin bad++; $display("FAIL partial_third_byte: ack %b want 0", k); end
      i2c_stop();
      model_write(b1, b2);
      total++;
      if (ev_addr.size() != 1) begin
         bad++; $display("FAIL partial_count: got %0d want 1", ev_addr.size());
      end else if (ev_addr[0] !== b1[7:1] || ev_data[0] !== {b1[0], b2}) begin
         bad++; $display("FAIL partial_wr: got %h/%h want %h/%h", ev_addr[0], ev_data[0], b1[7:1], {b1[0], b2});
      end
      ev_addr.delete(); ev_data.delete(); ev_err.delete();
      for (int r = 0; r < 16; r++) begin
         rd_addr_drv = 4'(r); @(negedge clk);
         total++; if (bus.rd_data !== model[r]) begin bad++; $display("FAIL partial_reg%0d: got %h want %h", r, bus.rd_data, model[r]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic k;
      logic [2:0] acks;
      send_frame(AW_BYTE, 8'h03, 8'h3C, acks); model_write(8'h03, 8'h3C);
      ev_addr.delete(); ev_data.delete(); ev_err.delete();
      i2c_start();
      send_byte(AW_BYTE, k);
      send_bits(8'h0A, 4);
      rd_addr_drv = 4'd1;
      reset = 1'b1;
      @(negedge clk);
      total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL rstmid_sda_oe: got %b want 0", bus.sda_oe); end
      total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      total++; if (bus.rd_data !== 9'h000) begin bad++; $display("FAIL rstmid_reg1: got %h want 000", bus.rd_data); end
      reset = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 9'h000;
      scl_set(1'b0); sda_drv = 1'b1; wait_q(1);
      send_frame(AW_BYTE, 8'h0D, 8'hC3, acks);
      model_write(8'h0D, 8'hC3);
      total++; if (acks !== 3'b111) begin bad++; $display("FAIL rstmid_acks: got %b want 111", acks); end
      total++;
      if (ev_addr.size() != 1 || ev_data[0] !== 9'h1C3) begin
         bad++; $display("FAIL rstmid_wr: got %0d writes want 1 of 1C3", ev_addr.size());
      end
      ev_addr.delete(); ev_data.delete(); ev_err.delete();
      for (int r = 0; r < 16; r++) begin
         rd_addr_drv = 4'(r); @(negedge clk);
         total++; if (bus.rd_data !== model[r]) begin bad++; $display("FAIL rstmid_reg%0d: got %h want %h", r, bus.rd_data, model[r]); end
      end
   endtask

   task automatic test_random_frames();
      logic [7:0] a, b1, b2;
      logic [2:0] acks;
      int rg;
      bit hit;
      for (int n = 0; n < 10; n++) begin
         a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : AW_BYTE;
         rg = $urandom_range(0, 17);
         b1 = {7'(rg), 1'($urandom)};
         b2 = 8'($urandom);
         hit = (a == AW_BYTE);
         send_frame(a, b1, b2, acks);
         total++;
         if (acks !== (hit ? 3'b111 : 3'b000)) begin
            bad++; $display("FAIL rand%0d_acks: addr %h got %b want %b", n, a, acks, hit ? 3'b111 : 3'b000);
         end
         total++;
         if (ev_addr.size() != (hit ? 1 : 0)) begin
            bad++; $display("FAIL rand%0d_count: got %0d want %0d", n, ev_addr.size(), hit ? 1 : 0);
         end else if (hit && (ev_addr[0] !== 7'(rg) || ev_data[0] !== {b1[0], b2} ||
                              ev_err[0] !== (rg >= 16))) begin
            bad++; $display("FAIL rand%0d_wr: got %h/%h/%b want %h/%h/%b", n, ev_addr[0], ev_data[0], ev_err[0],
                            7'(rg), {b1[0], b2}, rg >= 16);
         end
         if (hit) model_write(b1, b2);
         ev_addr.delete(); ev_data.delete(); ev_err.delete();
      end
      for (int r = 0; r < 16; r++) begin
         rd_addr_drv = 4'(r); @(negedge clk);
         total++; if (bus.rd_data !== model[r]) begin bad++; $display("FAIL rand_reg%0d: got %h want %h", r, bus.rd_data, model[r]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_no_match();
      test_clear();
      test_addr_err();
      test_partial_frames();
      test_reset_mid_frame();
      test_random_frames();
      repeat (10) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so a stuck bench still reports and ends.
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
